// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default sizing, width helpers and the fill-level
// flag decode used by both the single- and dual-clock FIFOs.
package fifo_pkg;

  localparam int unsigned FIFO_DEF_WIDTH = 22;
  localparam int unsigned FIFO_DEF_DEPTH = 16;

  typedef struct packed {
    logic full;
    logic almost_full;
    logic empty;
    logic almost_empty;
  } fifo_flags_t;

  // Count needs one extra bit over the pointer to represent DEPTH itself.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int unsigned depth);
    return (depth != 0) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic fifo_flags_t decode_flags(
    input int unsigned count,
    input int unsigned depth,
    input int unsigned afull_thresh,
    input int unsigned aempty_thresh
  );
    fifo_flags_t f;
    f.full         = (count == depth);
    f.almost_full  = (count >= afull_thresh);
    f.empty        = (count == 0);
    f.almost_empty = (count <= aempty_thresh);
    return f;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port FIFO storage: one write port, one read address.
// Read is combinational in FWFT mode, registered (reset to zero) otherwise.
module fifo_mem #(
  parameter int unsigned WIDTH  = 22,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned FWFT   = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rdata_o = mem[raddr_i];
    end else begin : g_std
      logic [WIDTH-1:0] rdata_q;

      // Holds the last word on idle or rejected reads.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)     rdata_q <= '0;
        else if (re_i) rdata_q <= mem[raddr_i];
      end

      assign rdata_o = rdata_q;
    end
  endgenerate

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with fill count, almost-full/empty thresholds,
// sticky overflow/underflow flags and optional first-word-fall-through.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH         = FIFO_DEF_WIDTH,
  parameter int unsigned DEPTH         = FIFO_DEF_DEPTH,
  parameter int unsigned PTR_WIDTH     = $clog2(DEPTH),
  parameter int unsigned AFULL_THRESH  = DEPTH - 2,
  parameter int unsigned AEMPTY_THRESH = 1,
  parameter int unsigned FWFT          = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [WIDTH-1:0]     wdata_i,
  input  logic                 wr_en_i,
  input  logic                 rd_en_i,
  input  logic                 clr_err_i,
  output logic [WIDTH-1:0]     rdata_o,
  output logic                 full_o,
  output logic                 almost_full_o,
  output logic                 empty_o,
  output logic                 almost_empty_o,
  output logic [PTR_WIDTH:0]   count_o,
  output logic                 overflow_o,
  output logic                 underflow_o
);

  generate
    if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
      $error("sync_fifo_flags: DEPTH must be a power of 2 and >= 2");
    end
    if (PTR_WIDTH + 1 != cnt_width(DEPTH)) begin : g_bad_ptr
      $error("sync_fifo_flags: PTR_WIDTH is derived from DEPTH and must not be overridden");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
      $error("sync_fifo_flags: AFULL_THRESH out of range 1..DEPTH");
    end
    if (AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
      $error("sync_fifo_flags: AEMPTY_THRESH out of range 0..DEPTH-1");
    end
  endgenerate

  logic [PTR_WIDTH-1:0] wr_ptr_q;
  logic [PTR_WIDTH-1:0] rd_ptr_q;
  logic [PTR_WIDTH:0]   count_q;
  logic                 overflow_q;
  logic                 underflow_q;
  fifo_flags_t          flags;
  logic                 wr_acc;
  logic                 rd_acc;

  always_comb begin
    flags = decode_flags(32'(count_q), DEPTH, AFULL_THRESH, AEMPTY_THRESH);
  end

  // Full rejects the write but not a simultaneous read; empty the reverse.
  assign wr_acc = wr_en_i & ~flags.full;
  assign rd_acc = rd_en_i & ~flags.empty;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + PTR_WIDTH'(1);
      if (rd_acc) rd_ptr_q <= rd_ptr_q + PTR_WIDTH'(1);

      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + (PTR_WIDTH + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_WIDTH + 1)'(1);
        default: count_q <= count_q;
      endcase

      // Set takes priority over clear so a same-cycle error is never lost.
      if (wr_en_i && flags.full) overflow_q <= 1'b1;
      else if (clr_err_i)        overflow_q <= 1'b0;

      if (rd_en_i && flags.empty) underflow_q <= 1'b1;
      else if (clr_err_i)         underflow_q <= 1'b0;
    end
  end

  fifo_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_WIDTH),
    .FWFT   (FWFT)
  ) u_mem (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata_i),
    .re_i    (rd_acc),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata_o)
  );

  assign full_o         = flags.full;
  assign almost_full_o  = flags.almost_full;
  assign empty_o        = flags.empty;
  assign almost_empty_o = flags.almost_empty;
  assign count_o        = count_q;
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: DEPTH=4 standard-read instance plus an FWFT instance.
module tb_sync_fifo_flags;

  localparam int W = 8;
  localparam int D = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [W-1:0] wdata;
  logic         wr_en, rd_en, clr_err;
  logic [W-1:0] rdata;
  logic         full, afull, empty, aempty, ovf, unf;
  logic [2:0]   count;

  logic [W-1:0] f_wdata;
  logic         f_wr_en, f_rd_en;
  logic [W-1:0] f_rdata;
  logic         f_full, f_afull, f_empty, f_aempty, f_ovf, f_unf;
  logic [2:0]   f_count;

  sync_fifo_flags #(
    .WIDTH(W), .DEPTH(D), .AFULL_THRESH(3), .AEMPTY_THRESH(1), .FWFT(0)
  ) dut (
    .clk_i(clk), .rst_i(rst), .wdata_i(wdata), .wr_en_i(wr_en), .rd_en_i(rd_en),
    .clr_err_i(clr_err), .rdata_o(rdata), .full_o(full), .almost_full_o(afull),
    .empty_o(empty), .almost_empty_o(aempty), .count_o(count),
    .overflow_o(ovf), .underflow_o(unf)
  );

  sync_fifo_flags #(
    .WIDTH(W), .DEPTH(D), .AFULL_THRESH(3), .AEMPTY_THRESH(1), .FWFT(1)
  ) dut_fwft (
    .clk_i(clk), .rst_i(rst), .wdata_i(f_wdata), .wr_en_i(f_wr_en), .rd_en_i(f_rd_en),
    .clr_err_i(1'b0), .rdata_o(f_rdata), .full_o(f_full), .almost_full_o(f_afull),
    .empty_o(f_empty), .almost_empty_o(f_aempty), .count_o(f_count),
    .overflow_o(f_ovf), .underflow_o(f_unf)
  );

  int checks = 0;
  int errors = 0;

  // Reference model and scoreboard
  logic [W-1:0] model_q[$];
  logic [W-1:0] rd_exp_q[$];
  int           m_count;
  logic         m_ovf, m_unf;
  logic [W-1:0] m_rdata;
  logic         last_racc;

  task automatic model_reset();
    model_q.delete();
    rd_exp_q.delete();
    m_count = 0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_rdata = '0;
    last_racc = 1'b0;
  endtask

  // Drives one cycle on the standard instance and advances the model; returns #1 after the edge.
  task automatic step(input logic we, input logic [W-1:0] wd, input logic re, input logic clr);
    logic wacc, racc;
    wr_en = we; wdata = wd; rd_en = re; clr_err = clr;
    wacc = we && (m_count != D);
    racc = re && (m_count != 0);
    if (wacc) model_q.push_back(wd);
    if (racc) begin
      m_rdata = model_q.pop_front();
      rd_exp_q.push_back(m_rdata);
    end
    if (we && m_count == D) m_ovf = 1'b1;
    else if (clr)           m_ovf = 1'b0;
    if (re && m_count == 0) m_unf = 1'b1;
    else if (clr)           m_unf = 1'b0;
    m_count = m_count + int'(wacc) - int'(racc);
    last_racc = racc;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wdata = '0;
    f_wr_en = 1'b0; f_rd_en = 1'b0; f_wdata = '0;
    model_reset();
    #1;
    checks++;
    if ({count, empty, aempty, full, afull, ovf, unf} !== {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_flags: got count=%0d e=%b ae=%b f=%b af=%b ov=%b un=%b, want 0 1 1 0 0 0 0",
               count, empty, aempty, full, afull, ovf, unf);
    end
    checks++;
    if (rdata !== 8'h00) begin
      errors++; $display("FAIL reset_rdata: got %h want 00", rdata);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fill();
    logic [W-1:0] wv [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, wv[i], 1'b0, 1'b0);
      checks++;
      if (count !== 3'(i + 1) || afull !== (i + 1 >= 3) || full !== (i + 1 == 4) ||
          empty !== 1'b0 || aempty !== (i + 1 <= 1)) begin
        errors++;
        $display("FAIL fill_%0d: got count=%0d af=%b f=%b e=%b ae=%b, want count=%0d af=%b f=%b e=0 ae=%b",
                 i, count, afull, full, empty, aempty, i + 1, i + 1 >= 3, i + 1 == 4, i + 1 <= 1);
      end
    end
    step(1'b1, 8'h55, 1'b0, 1'b0);
    checks++;
    if (count !== 3'd4 || ovf !== 1'b1 || full !== 1'b1) begin
      errors++; $display("FAIL overflow_write: got count=%0d ovf=%b full=%b, want 4 1 1", count, ovf, full);
    end
  endtask

  task automatic test_drain();
    logic [W-1:0] rv [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [W-1:0] exp;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      exp = rd_exp_q.pop_front();
      checks++;
      if (rdata !== exp || rdata !== rv[i] || count !== 3'(3 - i)) begin
        errors++;
        $display("FAIL drain_%0d: got rdata=%h count=%0d, want rdata=%h count=%0d", i, rdata, count, rv[i], 3 - i);
      end
    end
    checks++;
    if (empty !== 1'b1 || aempty !== 1'b1) begin
      errors++; $display("FAIL drain_empty: got empty=%b aempty=%b, want 1 1", empty, aempty);
    end
    step(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (unf !== 1'b1 || rdata !== 8'h44 || count !== 3'd0 || last_racc !== 1'b0) begin
      errors++; $display("FAIL underflow_read: got unf=%b rdata=%h count=%0d, want 1 44 0", unf, rdata, count);
    end
  endtask

  task automatic test_simultaneous();
    logic [W-1:0] exp;
    step(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (ovf !== 1'b0 || unf !== 1'b0) begin
      errors++; $display("FAIL clr_err: got ovf=%b unf=%b, want 0 0", ovf, unf);
    end
    step(1'b1, 8'hA1, 1'b0, 1'b0);
    step(1'b1, 8'hA2, 1'b0, 1'b0);
    step(1'b1, 8'hA3, 1'b1, 1'b0);
    exp = rd_exp_q.pop_front();
    checks++;
    if (count !== 3'd2 || rdata !== exp || rdata !== 8'hA1) begin
      errors++; $display("FAIL both_mid: got count=%0d rdata=%h, want 2 a1", count, rdata);
    end
    step(1'b1, 8'hA4, 1'b0, 1'b0);
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    step(1'b1, 8'hA6, 1'b1, 1'b0);
    exp = rd_exp_q.pop_front();
    checks++;
    if (count !== 3'd3 || ovf !== 1'b1 || rdata !== exp || rdata !== 8'hA2) begin
      errors++; $display("FAIL both_full: got count=%0d ovf=%b rdata=%h, want 3 1 a2", count, ovf, rdata);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      exp = rd_exp_q.pop_front();
      checks++;
      if (rdata !== exp) begin
        errors++; $display("FAIL both_order_%0d: got %h want %h", i, rdata, exp);
      end
    end
    step(1'b1, 8'hB7, 1'b1, 1'b0);
    checks++;
    if (count !== 3'd1 || unf !== 1'b1 || empty !== 1'b0) begin
      errors++; $display("FAIL both_empty: got count=%0d unf=%b empty=%b, want 1 1 0", count, unf, empty);
    end
    step(1'b0, '0, 1'b1, 1'b0);
    exp = rd_exp_q.pop_front();
    checks++;
    if (rdata !== 8'hB7 || rdata !== exp || empty !== 1'b1) begin
      errors++; $display("FAIL both_empty_read: got rdata=%h empty=%b, want b7 1", rdata, empty);
    end
  endtask

  task automatic test_wrap();
    logic [W-1:0] exp;
    int nxt = 1;
    step(1'b1, 8'h01, 1'b0, 1'b0);
    step(1'b1, 8'h02, 1'b0, 1'b0);
    for (int i = 3; i <= 13; i++) begin
      if (i <= 11) step(1'b1, W'(i), 1'b1, 1'b0);
      else         step(1'b0, '0, 1'b1, 1'b0);
      exp = rd_exp_q.pop_front();
      checks++;
      if (rdata !== exp || rdata !== W'(nxt) || full !== 1'b0 ||
          (i <= 11 && empty !== 1'b0) || (i == 13 && empty !== 1'b1)) begin
        errors++;
        $display("FAIL wrap_%0d: got rdata=%h full=%b empty=%b, want rdata=%h", i, rdata, full, empty, W'(nxt));
      end
      nxt++;
    end
  endtask

  task automatic test_mid_reset();
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, W'(8'hC0 + i), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (count !== 3'd3 || ovf !== 1'b1) begin
      errors++; $display("FAIL pre_reset: got count=%0d ovf=%b, want 3 1", count, ovf);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (count !== 3'd0 || empty !== 1'b1 || aempty !== 1'b1 || afull !== 1'b0 ||
        ovf !== 1'b0 || unf !== 1'b0 || rdata !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: got count=%0d e=%b ae=%b af=%b ov=%b un=%b rdata=%h, want 0 1 1 0 0 0 00",
               count, empty, aempty, afull, ovf, unf, rdata);
    end
    model_reset();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_clr_vs_overflow();
    for (int i = 0; i < 4; i++) step(1'b1, W'(8'hD0 + i), 1'b0, 1'b0);
    step(1'b1, 8'hDF, 1'b0, 1'b1);
    checks++;
    if (ovf !== 1'b1 || ovf !== m_ovf) begin
      errors++; $display("FAIL set_wins_clear: got ovf=%b want 1", ovf);
    end
    step(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (ovf !== 1'b0 || count !== 3'd4) begin
      errors++; $display("FAIL clear_after: got ovf=%b count=%0d want 0 4", ovf, count);
    end
  endtask

  task automatic test_fwft();
    logic [W-1:0] fq[$];
    checks++;
    if (f_empty !== 1'b1) begin
      errors++; $display("FAIL fwft_init_empty: got %b want 1", f_empty);
    end
    f_wr_en = 1'b1; f_wdata = 8'hA5; fq.push_back(8'hA5);
    @(posedge clk); #1;
    f_wr_en = 1'b0;
    checks++;
    if (f_empty !== 1'b0 || f_rdata !== fq[0] || f_count !== 3'd1 || f_aempty !== 1'b1) begin
      errors++; $display("FAIL fwft_show: got empty=%b rdata=%h count=%0d, want 0 a5 1", f_empty, f_rdata, f_count);
    end
    f_wr_en = 1'b1; f_wdata = 8'hB6; fq.push_back(8'hB6);
    @(posedge clk); #1;
    f_wr_en = 1'b0;
    checks++;
    if (f_rdata !== 8'hA5) begin
      errors++; $display("FAIL fwft_hold: got %h want a5", f_rdata);
    end
    void'(fq.pop_front());
    f_rd_en = 1'b1;
    @(posedge clk); #1;
    f_rd_en = 1'b0;
    checks++;
    if (f_empty !== 1'b0 || f_rdata !== fq[0]) begin
      errors++; $display("FAIL fwft_ack1: got empty=%b rdata=%h, want 0 b6", f_empty, f_rdata);
    end
    void'(fq.pop_front());
    f_rd_en = 1'b1;
    @(posedge clk); #1;
    f_rd_en = 1'b0;
    checks++;
    if (f_empty !== 1'b1 || f_count !== 3'd0 || f_full !== 1'b0 || f_afull !== 1'b0 ||
        f_ovf !== 1'b0 || f_unf !== 1'b0) begin
      errors++;
      $display("FAIL fwft_ack2: got empty=%b count=%0d full=%b af=%b ov=%b un=%b, want 1 0 0 0 0 0",
               f_empty, f_count, f_full, f_afull, f_ovf, f_unf);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_wrap();
    test_mid_reset();
    test_clr_vs_overflow();
    test_fwft();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
